corefifo_wr_ptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the CoreFIFO family. It generalises the combinational Gray-to-binary conversion into a registered, parametrised pointer engine. The block keeps the write pointer in binary and Gray form and resynchronises the read-side Gray pointer through a configurable synchroniser chain. It converts that pointer to binary in a pipeline stage and produces registered fill count, full, almost-full, write-acknowledge and overflow. It sits between the FIFO write port and the RAM write address/enable, in the write clock domain.

---
 rtl/corefifo_wr_ptr_ctrl.sv | 99 +++++++++
 tb/tb_corefifo_wr_ptr_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/corefifo_wr_ptr_ctrl.sv
// corefifo_wr_ptr_ctrl
//   Write-side pointer and flag engine for a CoreFIFO. Keeps the write pointer
//   in binary and Gray form. Brings the read-side Gray pointer across through a
//   synchroniser chain and converts it to binary in a registered stage. Produces
//   registered fill count, full, almost-full, write-ack and overflow pulses.
//
// Ports
//   clk              write-domain clock
//   rstn             synchronous active-low reset
//   we               write request
//   rptr_gray_async  read pointer (Gray) from the read domain
//   waddr            RAM write address
//   wen_ram          RAM write enable (combinational, we & ~full)
//   wptr_gray        registered Gray write pointer for the read domain
//   wcount           registered fill level, 0..DEPTH
//   full, afull      registered flags
//   wr_ack           one-cycle pulse per accepted write
//   overflow         one-cycle pulse per write attempted while full
module corefifo_wr_ptr_ctrl #(
    parameter int ADDRWIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_VAL   = (2**ADDRWIDTH)-2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rptr_gray_async,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 wen_ram,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic [ADDRWIDTH:0]   wcount,
    output logic                 full,
    output logic                 afull,
    output logic                 wr_ack,
    output logic                 overflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] DEPTH    = PW'(2**ADDRWIDTH);
    localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_VAL);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (AFULL_VAL < 1 || AFULL_VAL > 2**ADDRWIDTH) begin : g_bad_afull
        $error("AFULL_VAL must be in 1..DEPTH");
    end

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rptr_bin_comb;
    logic [PW-1:0] rptr_bin_q;
    logic [PW-1:0] count_next;
    logic          accept;

    assign accept        = we & ~full;
    assign wen_ram       = accept;
    assign waddr         = wptr_bin[ADDRWIDTH-1:0];
    assign wptr_bin_next = wptr_bin + {{ADDRWIDTH{1'b0}}, accept};
    // rptr_bin_q lags the true read pointer, so this can only over-report.
    assign count_next    = wptr_bin_next - rptr_bin_q;

    // Gray to binary on the last synchroniser flop: MSB copied, then each
    // lower bit is the running XOR from the top.
    always_comb begin
        rptr_bin_comb       = '0;
        rptr_bin_comb[PW-1] = sync_q[SYNC_STAGES-1][PW-1];
        for (int i = PW-1; i > 0; i--) begin
            rptr_bin_comb[i-1] = rptr_bin_comb[i] ^ sync_q[SYNC_STAGES-1][i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_bin   <= '0;
            wptr_gray  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            rptr_bin_q <= '0;
            wcount     <= '0;
            full       <= 1'b0;
            afull      <= 1'b0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wptr_bin   <= wptr_bin_next;
            wptr_gray  <= wptr_bin_next ^ (wptr_bin_next >> 1);
            sync_q[0]  <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            rptr_bin_q <= rptr_bin_comb;
            wcount     <= count_next;
            full       <= (count_next == DEPTH);
            afull      <= (count_next >= AFULL_TH);
            wr_ack     <= accept;
            overflow   <= we & full;
        end
    end

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
module tb_corefifo_wr_ptr_ctrl;

    localparam int AW    = 3;
    localparam int S     = 2;
    localparam int AF    = 6;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;
    localparam int MASK  = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          we;
    logic [PW-1:0] rptr_gray_async;
    logic [AW-1:0] waddr;
    logic          wen_ram;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] wcount;
    logic          full, afull, wr_ack, overflow;

    corefifo_wr_ptr_ctrl #(.ADDRWIDTH(AW), .SYNC_STAGES(S), .AFULL_VAL(AF)) dut (
        .clk(clk), .rstn(rstn), .we(we), .rptr_gray_async(rptr_gray_async),
        .waddr(waddr), .wen_ram(wen_ram), .wptr_gray(wptr_gray), .wcount(wcount),
        .full(full), .afull(afull), .wr_ack(wr_ack), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    function automatic int g2b(input logic [PW-1:0] g);
        int b = 0;
        for (int i = 0; i < PW; i++) if ((g >> i) != 0) b = b ^ int'(g >> i);
        return b & MASK;
    endfunction

    // Behavioural model: count of accepted writes (mod 16) and a delay line of
    // read-pointer values; the count at an edge sees the read pointer that was
    // presented S+1 edges earlier.
    int m_wr, m_count;
    bit m_full, m_afull, m_ack, m_ovf, m_valid;
    int hist [S+1];
    int wr_next, cnt_next;
    int rd_cur;

    always_comb begin
        wr_next  = (m_wr + ((we === 1'b1 && !m_full) ? 1 : 0)) & MASK;
        cnt_next = (wr_next - hist[0]) & MASK;
    end

    always @(posedge clk) begin
        if (!rstn) begin
            m_wr <= 0; m_count <= 0; m_full <= 0; m_afull <= 0;
            m_ack <= 0; m_ovf <= 0; m_valid <= 1;
            for (int i = 0; i <= S; i++) hist[i] <= 0;
        end else begin
            m_ack   <= (we && !m_full);
            m_ovf   <= (we && m_full);
            m_wr    <= wr_next;
            m_count <= cnt_next;
            m_full  <= (cnt_next == DEPTH);
            m_afull <= (cnt_next >= AF);
            for (int i = 0; i < S; i++) hist[i] <= hist[i+1];
            hist[S] <= g2b(rptr_gray_async);
        end
    end

    int prev_g = 0;
    bit seen_wrap = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("waddr",     waddr,     m_wr & 7);
            chk("wptr_gray", wptr_gray, b2g(m_wr));
            chk("wcount",    wcount,    m_count);
            chk("full",      full,      m_full);
            chk("afull",     afull,     m_afull);
            chk("wr_ack",    wr_ack,    m_ack);
            chk("overflow",  overflow,  m_ovf);
            chk("wen_ram",   wen_ram,   (we && !m_full));
            if (rstn) begin
                chk("wcount_le_depth", (wcount <= DEPTH), 1);
                chk("wcount_ge_occ", (int'(wcount) >= ((m_wr - rd_cur) & MASK)), 1);
                if (prev_g == 8 && wptr_gray == 0) seen_wrap <= 1;
            end
            prev_g <= wptr_gray;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int gseq [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    int acks, ncyc;

    initial begin
        // Reset with noisy inputs
        rstn = 0; we = 1; rd_cur = 0; rptr_gray_async = 4'h5;
        repeat (3) cyc();
        chk("rst_wcount", wcount, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_wptr_gray", wptr_gray, 0);
        chk("rst_full", full, 0);
        rstn = 1; we = 0; rd_cur = 0; rptr_gray_async = '0;
        repeat (4) cyc();

        // Fill
        for (int i = 0; i < 8; i++) begin
            we = 1;
            chk("fill_waddr", waddr, i);
            cyc();
            chk("fill_gray", wptr_gray, gseq[i]);
            chk("fill_ack", wr_ack, 1);
            chk("fill_afull", afull, (i >= 5));
            chk("fill_full", full, (i == 7));
        end
        chk("fill_wcount", wcount, 8);

        // Overflow
        cyc();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_no_ack", wr_ack, 0);
        chk("ovf_gray", wptr_gray, 12);
        chk("ovf_wcount", wcount, 8);
        we = 0;
        cyc();
        chk("ovf_clear", overflow, 0);

        // Release: read pointer advances by one while we stays high
        rd_cur = 1; rptr_gray_async = 4'h1; we = 1;
        repeat (3) cyc();
        chk("rel_still_full", full, 1);
        cyc();
        chk("rel_full", full, 0);
        chk("rel_wcount", wcount, 7);
        cyc();
        chk("rel_ack", wr_ack, 1);
        chk("rel_gray", wptr_gray, 13);
        we = 0;

        // Wrap: reader trails the writer by 3 entries
        acks = 0; ncyc = 0; we = 1;
        while (acks < 40 && ncyc < 400) begin
            if (((m_wr - rd_cur) & MASK) > 3) rd_cur = (rd_cur + 1) & MASK;
            rptr_gray_async = PW'(b2g(rd_cur));
            cyc();
            ncyc++;
            if (m_ack) acks++;
        end
        we = 0;
        chk("wrap_writes", acks, 40);
        chk("wrap_seen", seen_wrap, 1);

        // Drain, then build wcount=5 and reset mid-operation
        rd_cur = m_wr; rptr_gray_async = PW'(b2g(rd_cur));
        repeat (6) cyc();
        chk("drain_wcount", wcount, 0);
        we = 1;
        repeat (5) cyc();
        we = 0;
        chk("mid_wcount", wcount, 5);
        rstn = 0; we = 1; rd_cur = 0; rptr_gray_async = '0;
        cyc();
        chk("mr_wcount", wcount, 0);
        chk("mr_full", full, 0);
        chk("mr_afull", afull, 0);
        chk("mr_ack", wr_ack, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_gray", wptr_gray, 0);
        chk("mr_waddr", waddr, 0);
        rstn = 1; we = 1;
        chk("mr_first_waddr", waddr, 0);
        cyc();
        chk("mr_first_ack", wr_ack, 1);
        chk("mr_first_gray", wptr_gray, 1);
        chk("mr_first_wcount", wcount, 1);
        we = 0;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
